// File: rtl/nav_pkg.sv
// rtl/nav_pkg.sv - shared button indices, channel state encoding and direction priority
package nav_pkg;

   localparam int BTN_RIGHT = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_UP    = 2;
   localparam int BTN_DOWN  = 3;
   localparam int BTN_SEL   = 4;
   localparam int NUM_BTN   = 5;
   localparam int NUM_DIR   = 4;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } ch_state_t;

   // Direction priority, highest first.
   localparam int DIR_PRIO [NUM_DIR] = '{BTN_RIGHT, BTN_LEFT, BTN_UP, BTN_DOWN};

   // One-hot grant of the highest-priority set bit of a direction vector.
   function automatic logic [NUM_DIR-1:0] dir_first(input logic [NUM_DIR-1:0] req);
      logic [NUM_DIR-1:0] grant;
      logic               found;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_DIR; k++) begin
         if (!found && req[DIR_PRIO[k]]) begin
            grant[DIR_PRIO[k]] = 1'b1;
            found = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/nav_debounce_ch.sv
// rtl/nav_debounce_ch.sv - single-button synchronizer, debounce FSM and hold counter
module nav_debounce_ch
   import nav_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic            sync_q1;
   logic            sync_q2;
   ch_state_t       state;
   ch_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;

   // Two-flop synchronizer for the asynchronous pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

   // State and stability counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Saturating increment so a stuck compare can never wrap the count.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   // Next-state: a level is accepted only after it holds for the full window.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (sync_q2) begin
               state_nxt = ST_PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!sync_q2) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_HELD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         ST_HELD: begin
            if (!sync_q2) begin
               state_nxt = ST_RELEASE_WAIT;
               cnt_nxt   = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            if (sync_q2) begin
               state_nxt = ST_HELD;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs: level stays up through release bounce; rise marks the accepting cycle.
   always_comb begin
      level = 1'b0;
      rise  = 1'b0;
      if (state == ST_HELD || state == ST_RELEASE_WAIT) begin
         level = 1'b1;
      end
      if (state == ST_PRESS_WAIT && sync_q2 && cnt == CNT_LAST) begin
         rise = 1'b1;
      end
   end

endmodule

// File: rtl/nav_button_conditioner.sv
// rtl/nav_button_conditioner.sv - debounced levels, arbitrated move pulses; NAV_AUTO_REPEAT_EN adds hold auto-repeat
module nav_button_conditioner
   import nav_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 20000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] btn_raw,
   output logic [4:0] btn_level,
   output logic       right_p,
   output logic       left_p,
   output logic       up_p,
   output logic       down_p,
   output logic       select_p,
   output logic       any_held
);

   logic [NUM_BTN-1:0] rise;
   logic [NUM_DIR-1:0] press_win;
   logic [NUM_DIR-1:0] dir_nxt;
   logic [NUM_DIR-1:0] dir_q;
   logic               sel_q;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      nav_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .raw  (btn_raw[i]),
         .level(btn_level[i]),
         .rise (rise[i])
      );
   end

   // Simultaneous new presses collapse to one winner; losers are dropped.
   assign press_win = dir_first(rise[BTN_DOWN:BTN_RIGHT]);

`ifdef NAV_AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
   localparam logic [REP_W-1:0] REP_CNT_MAX = {REP_W{1'b1}};

   logic [NUM_DIR-1:0] held_win;
   logic [NUM_DIR-1:0] prev_win;
   logic [REP_W-1:0]   rep_cnt;
   logic               rep_phase;
   logic               win_stable;
   logic               rep_fire;

   assign held_win   = dir_first(btn_level[BTN_DOWN:BTN_RIGHT]);
   assign win_stable = (|held_win) && (held_win == prev_win);
   assign rep_fire   = win_stable &&
                       ((!rep_phase && rep_cnt == DELAY_LAST) ||
                        ( rep_phase && rep_cnt == PERIOD_LAST));

   // Repeat timer: initial delay phase, then fixed period; restarts on release or winner change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_win  <= '0;
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else begin
         prev_win <= held_win;
         if (!(|held_win)) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
         end else if (held_win != prev_win) begin
            rep_cnt   <= REP_W'(1);
            rep_phase <= 1'b0;
         end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
         end else if (rep_cnt != REP_CNT_MAX) begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end

   // A fresh press outranks a repeat landing in the same cycle.
   assign dir_nxt = (|press_win) ? press_win : (rep_fire ? held_win : '0);
`else
   assign dir_nxt = press_win;
`endif

   // Pulse register: one cycle after the rise strobe for directions and select alike.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir_q <= '0;
         sel_q <= 1'b0;
      end else begin
         dir_q <= dir_nxt;
         sel_q <= rise[BTN_SEL];
      end
   end

   assign right_p  = dir_q[BTN_RIGHT];
   assign left_p   = dir_q[BTN_LEFT];
   assign up_p     = dir_q[BTN_UP];
   assign down_p   = dir_q[BTN_DOWN];
   assign select_p = sel_q;
   assign any_held = |btn_level[BTN_DOWN:BTN_RIGHT];

endmodule

// File: tb/tb_nav_button_conditioner.sv
// tb/tb_nav_button_conditioner.sv - directed scoreboard bench for nav_button_conditioner
module tb_nav_button_conditioner;

   localparam int DEB = 4;
   localparam int CW  = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;
   // Cycles from the first sampling edge of a settled raw input to the debounced result.
   localparam int LAT = 2 + DEB;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] btn_raw;
   logic [4:0] btn_level;
   logic       right_p, left_p, up_p, down_p, select_p, any_held;
   logic       mon_en;

   int cyc  = 0;
   int nvec = 0;
   int nerr = 0;

   typedef struct {
      int         cyc;
      logic [4:0] v;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nav_button_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (CW),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .right_p  (right_p),
      .left_p   (left_p),
      .up_p     (up_p),
      .down_p   (down_p),
      .select_p (select_p),
      .any_held (any_held)
   );

   task automatic push(input int c, input logic [4:0] v);
      exp_t e;
      e.cyc = c;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Every cycle the pulse vector must equal the scoreboard entry for that cycle, else zero.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [4:0] expv;
         logic [4:0] obs;
         exp_t       e;
         expv = 5'b0;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e    = sb.pop_front();
            expv = e.v;
         end
         obs = {select_p, down_p, up_p, left_p, right_p};
         nvec++;
         assert (obs === expv) else begin
            nerr++;
            $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, obs, expv);
         end
      end
   end

   initial begin
      int n;
      int m;
      rst     = 1'b1;
      btn_raw = 5'b0;
      mon_en  = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_level", 16'(btn_level), 16'h0);
      chk("rst_pulses", 16'({select_p, down_p, up_p, left_p, right_p}), 16'h0);
      chk("rst_any_held", 16'(any_held), 16'h0);
      rst    = 1'b1;
      mon_en = 1'b1;

      // Idle after reset.
      repeat (20) @(negedge clk);
      chk("idle_level", 16'(btn_level), 16'h0);
      chk("idle_any_held", 16'(any_held), 16'h0);

      // Bouncy right press, then bouncy release.
      for (int i = 0; i < 10; i++) begin
         btn_raw[0] = (i % 2 == 0);
         @(negedge clk);
      end
      btn_raw[0] = 1'b1;
      n = cyc;
      push(n + 1 + LAT, 5'b00001);
      wait_cyc(n + LAT);
      chk("bounce_level_pre", 16'(btn_level[0]), 16'h0);
      wait_cyc(n + 1 + LAT);
      chk("bounce_level_up", 16'(btn_level[0]), 16'h1);
      btn_raw[0] = 1'b0;
      @(negedge clk);
      btn_raw[0] = 1'b1;
      @(negedge clk);
      btn_raw[0] = 1'b0;
      n = cyc;
      wait_cyc(n + LAT);
      chk("release_level_hold", 16'(btn_level[0]), 16'h1);
      wait_cyc(n + 1 + LAT);
      chk("release_level_down", 16'(btn_level[0]), 16'h0);
      repeat (4) @(negedge clk);
      chk("release_level_stays", 16'(btn_level[0]), 16'h0);

      // Four directions at once: only right pulses.
      btn_raw = 5'b01111;
      n = cyc;
      push(n + 1 + LAT, 5'b00001);
      wait_cyc(n + 2 + LAT);
      chk("multi_level", 16'(btn_level), 16'h0F);
      chk("multi_any_held", 16'(any_held), 16'h1);
      btn_raw = 5'b0;
      m = cyc;
      wait_cyc(m + 2 + LAT);
      chk("multi_release_level", 16'(btn_level), 16'h0);
      chk("multi_release_any", 16'(any_held), 16'h0);

      // Right held, then up pressed on top.
      btn_raw = 5'b00001;
      n = cyc;
      push(n + 1 + LAT, 5'b00001);
      wait_cyc(n + 2);
      btn_raw = 5'b00101;
      push(n + 3 + LAT, 5'b00100);
`ifdef NAV_AUTO_REPEAT_EN
      push(n + 1 + LAT + RD, 5'b00001);
      push(n + 1 + LAT + RD + RP, 5'b00001);
`endif
      wait_cyc(n + 10);
      chk("two_dir_level", 16'(btn_level), 16'h05);
      btn_raw = 5'b0;
      m = cyc;
      wait_cyc(m + 2 + LAT);
      chk("two_dir_release", 16'(btn_level), 16'h0);

      // Reset in PRESS_WAIT at count 2 discards the partial count.
      btn_raw = 5'b00001;
      n = cyc;
      wait_cyc(n + 5);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_level", 16'(btn_level), 16'h0);
      rst = 1'b1;
      m = cyc;
      push(m + 1 + LAT, 5'b00001);
      wait_cyc(m + LAT);
      chk("midrst_level_pre", 16'(btn_level[0]), 16'h0);
      wait_cyc(m + 1 + LAT);
      chk("midrst_level_up", 16'(btn_level[0]), 16'h1);
      @(negedge clk);
      btn_raw = 5'b0;
      m = cyc;
      wait_cyc(m + 2 + LAT);
      chk("midrst_release", 16'(btn_level), 16'h0);

      // Long left hold: repeat cadence only in the auto-repeat build.
      btn_raw = 5'b00010;
      n = cyc;
      push(n + 1 + LAT, 5'b00010);
`ifdef NAV_AUTO_REPEAT_EN
      push(n + 1 + LAT + RD, 5'b00010);
      push(n + 1 + LAT + RD + RP, 5'b00010);
      push(n + 1 + LAT + RD + 2 * RP, 5'b00010);
      push(n + 1 + LAT + RD + 3 * RP, 5'b00010);
`endif
      wait_cyc(n + 29);
      chk("hold_left_level", 16'(btn_level), 16'h02);
      btn_raw = 5'b0;
      m = cyc;
      wait_cyc(m + 2 + LAT);
      chk("hold_left_release", 16'(btn_level), 16'h0);

      // Select with right together, then select alone held long: never repeats.
      btn_raw = 5'b10001;
      n = cyc;
      push(n + 1 + LAT, 5'b10001);
      wait_cyc(n + 2 + LAT);
      btn_raw = 5'b10000;
      wait_cyc(n + 3 + LAT);
      chk("sel_any_held_on", 16'(any_held), 16'h1);
      wait_cyc(n + 11 + LAT);
      chk("sel_any_held_off", 16'(any_held), 16'h0);
      chk("sel_level", 16'(btn_level), 16'h10);
      wait_cyc(n + 25);
      btn_raw = 5'b0;
      m = cyc;
      wait_cyc(m + 2 + LAT);
      chk("sel_release", 16'(btn_level), 16'h0);

      repeat (5) @(negedge clk);
      chk("sb_drained", 16'(sb.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
